// File: rtl/pipe_pkg.sv
// Shared types and constants for the global-stall pipeline and its output drain.
package pipe_pkg;
  localparam int DATA_W      = 32;
  localparam int PIPE_STAGES = 3;

  typedef logic [DATA_W-1:0] pipe_beat_t;
endpackage

// File: rtl/pipeline_drain_sync_fifo.sv
// sync_fifo: storage array with wrap-around pointers and an explicit occupancy count.
// The caller gates push/pop; this block trusts them and never refuses.
module sync_fifo #(
  parameter int W     = 32,
  parameter int DEPTH = 8,
  parameter int AW    = $clog2(DEPTH),
  parameter int CW    = $clog2(DEPTH) + 1
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          push_i,
  input  logic          pop_i,
  input  logic [W-1:0]  wdata_i,
  output logic [W-1:0]  rdata_o,
  output logic [CW-1:0] count_o,
  output logic [CW-1:0] count_next_o,
  output logic          full_o,
  output logic          empty_o
);
  logic [W-1:0]  mem_q [DEPTH];
  logic [AW-1:0] wr_ptr_q;
  logic [AW-1:0] rd_ptr_q;
  logic [CW-1:0] count_q;
  logic [CW-1:0] count_d;

  always_comb begin
    count_d = count_q;
    case ({push_i, pop_i})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
    end else begin
      if (push_i) begin
        mem_q[wr_ptr_q] <= wdata_i;
        wr_ptr_q        <= wr_ptr_q + 1'b1;
      end
      if (pop_i) rd_ptr_q <= rd_ptr_q + 1'b1;
      count_q <= count_d;
    end
  end

  // Head is read straight from storage so it holds steady while not popped.
  assign rdata_o      = mem_q[rd_ptr_q];
  assign count_o      = count_q;
  assign count_next_o = count_d;
  assign full_o       = (count_q == CW'(DEPTH));
  assign empty_o      = (count_q == '0);
endmodule

// File: rtl/pipeline_drain.sv
// Output drain for the global-stall pipeline: buffers beats, raises stall early.
// Optional saturating statistics counters enabled by PIPELINE_DRAIN_STATS_EN.
module pipeline_drain
  import pipe_pkg::*;
#(
  parameter int DATA_W       = pipe_pkg::DATA_W,
  parameter int DEPTH        = 8,
  parameter int STALL_MARGIN = 2
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic [DATA_W-1:0]        pipe_data,
  input  logic                     pipe_valid,
  input  logic                     flush,
  output logic                     stall,
  output logic [DATA_W-1:0]        dn_data,
  output logic                     dn_valid,
  input  logic                     dn_ready,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     overflow,
  output logic                     flush_seen
`ifdef PIPELINE_DRAIN_STATS_EN
  ,
  output logic [15:0]              stat_beats,
  output logic [15:0]              stat_stall_cycles
`endif
);
  localparam int CW = $clog2(DEPTH) + 1;
  localparam logic [CW-1:0] STALL_TH = CW'(DEPTH - STALL_MARGIN);

  logic          full;
  logic          empty;
  logic          pop;
  logic          wr;
  logic [CW-1:0] count_next;
  logic          stall_q;
  logic          overflow_q;
  logic          flush_seen_q;

  // Handshake: a beat moves downstream only in a cycle with dn_valid and dn_ready both high.
  assign pop = dn_valid & dn_ready;
  assign wr  = pipe_valid & (~full | pop);

  sync_fifo #(.W(DATA_W), .DEPTH(DEPTH)) u_fifo (
    .clk          (clk),
    .reset        (reset),
    .push_i       (wr),
    .pop_i        (pop),
    .wdata_i      (pipe_data),
    .rdata_o      (dn_data),
    .count_o      (count),
    .count_next_o (count_next),
    .full_o       (full),
    .empty_o      (empty)
  );

  assign dn_valid = ~empty;

  always_ff @(posedge clk) begin
    if (reset) begin
      stall_q      <= 1'b0;
      overflow_q   <= 1'b0;
      flush_seen_q <= 1'b0;
    end else begin
      stall_q      <= (count_next >= STALL_TH);
      flush_seen_q <= flush;
      if (pipe_valid && full && !pop) overflow_q <= 1'b1;
    end
  end

  assign stall      = stall_q;
  assign overflow   = overflow_q;
  assign flush_seen = flush_seen_q;

`ifdef PIPELINE_DRAIN_STATS_EN
  logic [15:0] stat_beats_q;
  logic [15:0] stat_stall_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      stat_beats_q <= '0;
      stat_stall_q <= '0;
    end else begin
      if (wr && stat_beats_q != 16'hFFFF)      stat_beats_q <= stat_beats_q + 1'b1;
      if (stall_q && stat_stall_q != 16'hFFFF) stat_stall_q <= stat_stall_q + 1'b1;
    end
  end

  assign stat_beats        = stat_beats_q;
  assign stat_stall_cycles = stat_stall_q;
`endif
endmodule

// File: tb/tb_pipeline_drain.sv
// Directed bench for pipeline_drain; covers the stats counters when
// PIPELINE_DRAIN_STATS_EN is defined.
module tb_pipeline_drain;
  import pipe_pkg::*;

  localparam int DEPTH = 8;

  logic        clk = 1'b0;
  logic        reset;
  pipe_beat_t  pipe_data;
  logic        pipe_valid;
  logic        flush;
  logic        stall;
  pipe_beat_t  dn_data;
  logic        dn_valid;
  logic        dn_ready;
  logic [3:0]  count;
  logic        overflow;
  logic        flush_seen;
`ifdef PIPELINE_DRAIN_STATS_EN
  logic [15:0] stat_beats;
  logic [15:0] stat_stall_cycles;
`endif

  int checks   = 0;
  int failures = 0;

  pipeline_drain #(.DATA_W(32), .DEPTH(DEPTH), .STALL_MARGIN(2)) dut (
    .clk        (clk),
    .reset      (reset),
    .pipe_data  (pipe_data),
    .pipe_valid (pipe_valid),
    .flush      (flush),
    .stall      (stall),
    .dn_data    (dn_data),
    .dn_valid   (dn_valid),
    .dn_ready   (dn_ready),
    .count      (count),
    .overflow   (overflow),
    .flush_seen (flush_seen)
`ifdef PIPELINE_DRAIN_STATS_EN
    ,
    .stat_beats        (stat_beats),
    .stat_stall_cycles (stat_stall_cycles)
`endif
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic push(input logic [31:0] d);
    pipe_valid = 1'b1;
    pipe_data  = d;
    step();
    pipe_valid = 1'b0;
  endtask

  initial begin
    reset      = 1'b1;
    pipe_valid = 1'b1;
    pipe_data  = 32'hDEAD;
    flush      = 1'b0;
    dn_ready   = 1'b0;
    step();
    step();
    chk("rst_stall", {31'd0, stall}, 32'd0);
    chk("rst_dn_valid", {31'd0, dn_valid}, 32'd0);
    chk("rst_dn_data", dn_data, 32'd0);
    chk("rst_count", {28'd0, count}, 32'd0);
    chk("rst_overflow", {31'd0, overflow}, 32'd0);
    chk("rst_flush_seen", {31'd0, flush_seen}, 32'd0);
    reset      = 1'b0;
    pipe_valid = 1'b0;
    step();
    chk("post_rst_count", {28'd0, count}, 32'd0);

    // Fill 1..6 with downstream blocked; stall rises when occupancy hits 6.
    for (int i = 1; i <= 6; i++) begin
      push(32'(i));
      chk("fill_count", {28'd0, count}, 32'(i));
      chk("fill_stall", {31'd0, stall}, (i >= 6) ? 32'd1 : 32'd0);
      chk("fill_head", dn_data, 32'd1);
      chk("fill_dn_valid", {31'd0, dn_valid}, 32'd1);
    end
    push(32'h7);
    chk("seventh_count", {28'd0, count}, 32'd7);
    chk("seventh_overflow", {31'd0, overflow}, 32'd0);
    chk("seventh_stall", {31'd0, stall}, 32'd1);

    // Drain all seven in order.
    dn_ready = 1'b1;
    for (int k = 1; k <= 7; k++) begin
      chk("drain_data", dn_data, 32'(k));
      step();
      chk("drain_count", {28'd0, count}, 32'(7 - k));
      chk("drain_stall", {31'd0, stall}, ((7 - k) >= 6) ? 32'd1 : 32'd0);
    end
    chk("drain_dn_valid", {31'd0, dn_valid}, 32'd0);
    dn_ready = 1'b0;

    // Fill to full, then push and pop together.
    for (int i = 0; i < 8; i++) push(32'h10 + 32'(i));
    chk("full_count", {28'd0, count}, 32'd8);
    chk("full_head", dn_data, 32'h10);
    pipe_valid = 1'b1;
    pipe_data  = 32'hAA;
    dn_ready   = 1'b1;
    step();
    pipe_valid = 1'b0;
    dn_ready   = 1'b0;
    chk("pp_count", {28'd0, count}, 32'd8);
    chk("pp_head", dn_data, 32'h11);
    chk("pp_overflow", {31'd0, overflow}, 32'd0);

    // Push into a full FIFO with no pop: beat dropped, overflow sticks.
    push(32'hBB);
    chk("ovf_flag", {31'd0, overflow}, 32'd1);
    chk("ovf_count", {28'd0, count}, 32'd8);
    dn_ready = 1'b1;
    for (int k = 1; k <= 7; k++) begin
      chk("ovf_drain_data", dn_data, 32'h10 + 32'(k));
      step();
    end
    chk("ovf_drain_tail", dn_data, 32'hAA);
    step();
    dn_ready = 1'b0;
    chk("ovf_drain_count", {28'd0, count}, 32'd0);
    chk("ovf_drain_valid", {31'd0, dn_valid}, 32'd0);
    chk("ovf_sticky", {31'd0, overflow}, 32'd1);

    // Flush with occupancy 3, then a flush carrying a beat.
    for (int i = 1; i <= 3; i++) push(32'h20 + 32'(i));
    flush = 1'b1;
    step();
    flush = 1'b0;
    chk("flush_seen_hi", {31'd0, flush_seen}, 32'd1);
    chk("flush_count", {28'd0, count}, 32'd3);
    step();
    chk("flush_seen_lo", {31'd0, flush_seen}, 32'd0);
    chk("flush_count2", {28'd0, count}, 32'd3);
    flush = 1'b1;
    push(32'h24);
    flush = 1'b0;
    chk("flush_beat_count", {28'd0, count}, 32'd4);
    dn_ready = 1'b1;
    for (int k = 1; k <= 4; k++) begin
      chk("flush_drain_data", dn_data, 32'h20 + 32'(k));
      step();
    end
    dn_ready = 1'b0;
    chk("flush_drain_valid", {31'd0, dn_valid}, 32'd0);

    reset = 1'b1;
    step();
    reset = 1'b0;
    chk("rst2_overflow", {31'd0, overflow}, 32'd0);
    chk("rst2_count", {28'd0, count}, 32'd0);

`ifdef PIPELINE_DRAIN_STATS_EN
    chk("stat_beats_rst", {16'd0, stat_beats}, 32'd0);
    for (int i = 1; i <= 6; i++) push(32'(i));
    step();
    step();
    step();
    chk("stat_beats_6", {16'd0, stat_beats}, 32'd6);
    chk("stat_stall_3", {16'd0, stat_stall_cycles}, 32'd3);
    reset = 1'b1;
    step();
    reset = 1'b0;
    pipe_valid = 1'b1;
    dn_ready   = 1'b1;
    for (int i = 0; i < 70000; i++) begin
      pipe_data = 32'(i);
      step();
    end
    pipe_valid = 1'b0;
    dn_ready   = 1'b0;
    chk("stat_beats_sat", {16'd0, stat_beats}, 32'hFFFF);
    chk("stat_stall_zero", {16'd0, stat_stall_cycles}, 32'd0);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/pipeline_drain.md
Name: pipeline_drain

Overview:
- Consumer at the output end of the global-stall pipeline.
- Captures each (outputs, out_valid) beat into a small FIFO and presents it downstream on a valid/ready handshake.
- Drives the pipeline's global `stall` input when buffer space runs low, so no valid beat is ever lost.
- Sits between the pipeline unit and the downstream consumer; flush never discards beats already captured.

Parameters:
- DATA_W, 32, width of captured beat.
- DEPTH, 8, FIFO entries (power of 2, >= 4).
- STALL_MARGIN, 2, free slots reserved when stall is raised. Covers the registered stall plus the beat already at the pipeline output.

Ports:
- clk  input  1  clock, all logic on rising edge
- reset  input  1  synchronous, active-high; clears all state
- pipe_data  input  DATA_W  pipeline `outputs`
- pipe_valid  input  1  pipeline `out_valid`
- flush  input  1  same flush the pipeline sees; used only for the flush_seen pulse
- stall  output  1  registered global stall to the pipeline
- dn_data  output  DATA_W  head-of-FIFO data
- dn_valid  output  1  FIFO non-empty
- dn_ready  input  1  downstream accepts dn_data this cycle
- count  output  $clog2(DEPTH)+1  current occupancy
- overflow  output  1  sticky error; beat arrived while full
- flush_seen  output  1  one-cycle pulse, registered copy of flush

Behaviour:
- Reset values (synchronous, active-high, reset takes priority over everything):
  - stall=0, dn_valid=0, dn_data=0, count=0, overflow=0, flush_seen=0
  - read and write pointers = 0
- Write rule: a write occurs when pipe_valid=1 and (count<DEPTH or a pop occurs the same cycle).
- Read rule:
  - A pop occurs when dn_valid=1 and dn_ready=1.
  - dn_data is the head entry, combinationally from storage; it is stable while dn_valid=1 and dn_ready=0.
- Simultaneous push and pop: count is unchanged and both pointers advance. This is legal when full (count=DEPTH), because the pop frees the slot.
- Empty with pipe_valid=1: the beat is written and appears on dn_valid next cycle. Latency is 1 cycle; there is no bypass.
- Full with pipe_valid=1 and no pop:
  - the beat is dropped and overflow sets and stays set until reset
  - count is unchanged
  - in correct operation this never happens, and it is a verification assertion
- Pointers: $clog2(DEPTH) bits, natural wrap-around at DEPTH. count holds full/empty explicitly (0 to DEPTH).
- Stall:
  - `stall <= (count_next >= DEPTH-STALL_MARGIN)`, where count_next is the post-update occupancy.
  - Deasserts the cycle after count_next drops below the threshold; there is no hysteresis.
  - While stalled, the pipeline produces at most one further valid beat. The margin guarantees it fits.
- Flush:
  - flush_seen <= flush.
  - FIFO contents, count and stall are unaffected; captured beats are committed.
  - A beat presented with pipe_valid=1 in the same cycle as flush is still captured.
- State machine: none beyond FIFO occupancy. Stall is a registered comparator.

Optional Feature:
- Macro: PIPELINE_DRAIN_STATS_EN.
- When defined, adds two outputs:
  - stat_beats[15:0]: saturating count of writes
  - stat_stall_cycles[15:0]: saturating count of cycles with stall=1
- Both counters clear on reset and hold at 16'hFFFF.
- When undefined, the ports and counters are absent and behaviour is otherwise identical.

Decomposition:
- Shared package pipe_pkg:
  - localparam DATA_W=32
  - localparam PIPE_STAGES=3
  - typedef pipe_beat_t (logic [DATA_W-1:0])
- One sub-module: sync_fifo, a parameterised storage array with pointers and count, and push/pop/full/empty.
- pipeline_drain owns the stall comparator, the overflow flag, flush_seen and the stats.

Test Plan:
- Reset: hold reset 2 cycles with pipe_valid=1 and pipe_data=32'hDEAD -> all outputs 0, count=0, nothing captured.
- Fill with dn_ready=0:
  - push 32'h1..32'h6, one per cycle -> stall=1 the cycle after count reaches 6
  - push a 7th beat 32'h7 during stall -> count=7, overflow=0
- Drain: from count=7, dn_ready=1 continuously -> dn_data sequence 1..7 in order; stall=0 once count<=5; dn_valid=0 after 7 pops.
- Full with simultaneous push and pop: count=8, pipe_valid=1 (32'hAA), dn_ready=1 -> count stays 8, head advances, 32'hAA stored at tail, overflow=0.
- Overflow: count=8, dn_ready=0, pipe_valid=1 (32'hBB) -> overflow=1, count=8, 32'hBB never appears on dn_data; overflow persists until reset.
- Flush and stats: assert flush 1 cycle with count=3 -> flush_seen pulses 1 cycle, count=3 and contents intact; with PIPELINE_DRAIN_STATS_EN, 70000 writes -> stat_beats=16'hFFFF.
